// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex segment patterns,
// the nibble decode function and the per-slot state type.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Segment order {a,b,c,d,e,f,g}, active-high
  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  function automatic logic [SEG_W-1:0] seg7_hex(input logic [3:0] nibble);
    logic [SEG_W-1:0] s;
    case (nibble)
      4'h0:    s = SEG_HEX_0;
      4'h1:    s = SEG_HEX_1;
      4'h2:    s = SEG_HEX_2;
      4'h3:    s = SEG_HEX_3;
      4'h4:    s = SEG_HEX_4;
      4'h5:    s = SEG_HEX_5;
      4'h6:    s = SEG_HEX_6;
      4'h7:    s = SEG_HEX_7;
      4'h8:    s = SEG_HEX_8;
      4'h9:    s = SEG_HEX_9;
      4'hA:    s = SEG_HEX_A;
      4'hB:    s = SEG_HEX_B;
      4'hC:    s = SEG_HEX_C;
      4'hD:    s = SEG_HEX_D;
      4'hE:    s = SEG_HEX_E;
      default: s = SEG_HEX_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_seg7_dec.sv
// Combinational nibble to 7-segment decoder (full hex, active-high segments).
module hex_seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = seg7_hex(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment scan driver with dwell prescaler and
// anti-ghosting guard. Optional leading-zero suppression: SEG7_LEADING_ZERO_BLANK_EN.
//
//   state    | meaning
//   ST_GUARD | cnt < GUARD: all digits dark while the previous digit discharges
//   ST_DRIVE | cnt >= GUARD: digit idx driven from the shadow registers
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    slot_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  slot_state_t             state;
  logic                    slot_last;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    sel_suppress;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [SEG_W-1:0]        dec_seg;

  always_comb begin
    state     = (cnt < CNT_GUARD) ? ST_GUARD : ST_DRIVE;
    slot_last = (cnt == CNT_LAST);
  end

  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    an_onehot  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_nibble   = shadow_value[4*k +: 4];
        sel_dp       = shadow_dp[k];
        sel_blank    = shadow_blank[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk from the top digit down; a digit is suppressed only while every
  // nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    zero_run     = 1'b1;
    sel_suppress = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_value[4*k +: 4] == 4'h0);
      if ((idx == IDX_W'(k)) && (k > 0)) begin
        sel_suppress = zero_run;
      end
    end
  end
`else
  always_comb begin
    sel_suppress = 1'b0;
  end
`endif

  hex_seg7_dec u_dec (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      cnt          <= '0;
      idx          <= '0;
      seg          <= '0;
      dp           <= 1'b0;
      an           <= '0;
      slot_tick    <= 1'b0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end

      if (en) begin
        slot_tick <= slot_last;
        if (slot_last) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        if (state == ST_GUARD) begin
          an  <= '0;
          seg <= '0;
          dp  <= 1'b0;
        end else begin
          an  <= an_onehot;
          seg <= (sel_blank || sel_suppress) ? '0 : dec_seg;
          dp  <= sel_blank ? 1'b0 : sel_dp;
        end
      end else begin
        // Scan position is frozen so re-enable resumes mid-slot
        an        <= '0;
        seg       <= '0;
        dp        <= 1'b0;
        slot_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, CLK_DIV=8, GUARD=2).
// Honours SEG7_LEADING_ZERO_BLANK_EN in its reference model.
module tb_seg7_scan_driver;

  localparam int ND      = 4;
  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          slot_tick;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: scan position as plain integers, display rules as arithmetic
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  exp_an = '0;
  logic [6:0]  exp_seg = '0;
  logic        exp_dp = 1'b0;
  logic        exp_tick = 1'b0;

  function automatic logic [6:0] model_seg(input int k);
    logic [3:0] nib;
    nib = 4'((m_val >> (4*k)) & 16'hF);
    if (m_blank[k]) return 7'd0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (k > 0 && (m_val >> (4*k)) == 16'd0) return 7'd0;
`endif
    return seg_ref[nib];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_idx <= 0; m_val <= '0; m_dp <= '0; m_blank <= '0;
      exp_an <= '0; exp_seg <= '0; exp_dp <= 1'b0; exp_tick <= 1'b0;
    end else begin
      if (load) begin
        m_val <= value; m_dp <= dp_in; m_blank <= blank_in;
      end
      if (en) begin
        exp_tick <= (m_cnt == CLK_DIV - 1);
        if (m_cnt < GUARD) begin
          exp_an <= '0; exp_seg <= '0; exp_dp <= 1'b0;
        end else begin
          exp_an  <= 4'(1 << m_idx);
          exp_seg <= model_seg(m_idx);
          exp_dp  <= m_blank[m_idx] ? 1'b0 : m_dp[m_idx];
        end
        m_cnt <= (m_cnt + 1) % CLK_DIV;
        if (m_cnt == CLK_DIV - 1) m_idx <= (m_idx + 1) % ND;
      end else begin
        exp_an <= '0; exp_seg <= '0; exp_dp <= 1'b0; exp_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if ({an, seg, dp, slot_tick} !== {exp_an, exp_seg, exp_dp, exp_tick}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                 $time, an, seg, dp, slot_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
    end
  end

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Output bundle {an, seg, dp, slot_tick} packed into 13 bits
  function automatic logic [15:0] pack(input logic [3:0] a, input logic [6:0] s,
                                       input logic d, input logic t);
    return {3'b000, a, s, d, t};
  endfunction

  task automatic wait_an(input logic [3:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an === a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_an timeout got an=%b want an=%b", an, a);
    end
  endtask

  task automatic wait_model(input int c, input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m_cnt == c && m_idx == d) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_model timeout got cnt=%0d idx=%0d want cnt=%0d idx=%0d", m_cnt, m_idx, c, d);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] scan_an  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [6:0] scan_seg [4] = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    lit("reset_outputs", pack(an, seg, dp, slot_tick), 16'h0000);

    // Basic scan of 12AF
    rst = 1'b0; load = 1'b1; value = 16'h12AF;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j % 8 < 2)
        lit("scan_guard", pack(an, seg, dp, slot_tick), 16'h0000);
      else
        lit("scan_drive", pack(an, seg, dp, slot_tick),
            pack(scan_an[j/8], scan_seg[j/8], 1'b0, (j % 8) == 7));
    end

    // Every nibble through digit 0
    for (int n = 0; n < 16; n++) begin
      do_load(16'h1230 | 16'(n), 4'b0000, 4'b0000);
      wait_an(4'b0001);
      lit("hex_decode", {9'd0, seg}, {9'd0, seg_ref[n]});
    end

    // Blanking and decimal point
    do_load(16'h8888, 4'b0001, 4'b0100);
    wait_an(4'b0100);
    lit("blank_digit2", pack(an, seg, dp, 1'b0), pack(4'b0100, 7'b0000000, 1'b0, 1'b0));
    wait_an(4'b0001);
    lit("dp_digit0", pack(an, seg, dp, 1'b0), pack(4'b0001, 7'b1111111, 1'b1, 1'b0));

    // Enable dropped after the cnt=5 output of digit 2
    wait_model(6, 2);
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      lit("en_low_dark", pack(an, seg, dp, slot_tick), 16'h0000);
    end
    en = 1'b1;
    @(negedge clk);
    lit("resume_1", pack(an, seg, dp, slot_tick), pack(4'b0100, 7'd0, 1'b0, 1'b0));
    @(negedge clk);
    lit("resume_2", pack(an, seg, dp, slot_tick), pack(4'b0100, 7'd0, 1'b0, 1'b1));
    @(negedge clk);
    lit("resume_wrap", pack(an, seg, dp, slot_tick), 16'h0000);

    // Reset in slot 3
    wait_model(4, 3);
    rst = 1'b1;
    @(negedge clk);
    lit("rst_mid_scan", pack(an, seg, dp, slot_tick), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    lit("rst_guard0", pack(an, seg, dp, slot_tick), 16'h0000);
    @(negedge clk);
    lit("rst_guard1", pack(an, seg, dp, slot_tick), 16'h0000);
    @(negedge clk);
    lit("rst_restart", pack(an, seg, dp, slot_tick), pack(4'b0001, 7'b1111110, 1'b0, 1'b0));

    // Leading zeros
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_an(4'b1000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lit("lz_digit3", {9'd0, seg}, 16'h0000);
`else
    lit("lz_digit3", {9'd0, seg}, {9'd0, 7'b1111110});
`endif
    wait_an(4'b0001);
    lit("lz_digit0", {9'd0, seg}, {9'd0, 7'b1111110});
    wait_an(4'b0010);
    lit("lz_digit1", {9'd0, seg}, {9'd0, 7'b1011011});
    wait_an(4'b0100);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lit("lz_digit2", {9'd0, seg}, 16'h0000);
`else
    lit("lz_digit2", {9'd0, seg}, {9'd0, 7'b1111110});
`endif

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
